// File: rtl/square_motion_if.sv
// Bundles the per-frame timing, collision and position signals of one square object.
// master drives the requests and pulses; slave is the motion controller.
interface square_motion_if;
   logic               startOfFrame;
   logic               launch;
   logic               halt;
   logic               collisionX;
   logic               collisionY;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic               moving;

   modport master (
      output startOfFrame, launch, halt, collisionX, collisionY,
      input  topLeftX, topLeftY, moving
   );

   modport slave (
      input  startOfFrame, launch, halt, collisionX, collisionY,
      output topLeftX, topLeftY, moving
   );
endinterface

// File: rtl/square_motion_ctrl.sv
// Per-frame motion controller for one square object: fixed-point integration, bounces, cooldown.
// Optional feature macro: SQUARE_MOTION_GRAVITY_EN adds GRAVITY to speedY on every frame update.
module square_motion_ctrl #(
   parameter int OBJECT_WIDTH    = 32,
   parameter int OBJECT_HEIGHT   = 32,
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int INIT_X          = 280,
   parameter int INIT_Y          = 185,
   parameter int INIT_SPEED_X    = 40,
   parameter int INIT_SPEED_Y    = -80,
   parameter int MAX_SPEED       = 512,
   parameter int COOLDOWN_FRAMES = 4,
   parameter int GRAVITY         = 3
) (
   input  logic             clk,
   input  logic             resetN,
   square_motion_if.slave   bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COOLDOWN = 2'd2} state_t;

   localparam logic signed [10:0] X_LIM = 11'(SCREEN_W - OBJECT_WIDTH);
   localparam logic signed [10:0] Y_LIM = 11'(SCREEN_H - OBJECT_HEIGHT);
`ifdef SQUARE_MOTION_GRAVITY_EN
   localparam int GRAV_STEP = GRAVITY;
`else
   localparam int GRAV_STEP = 0 * GRAVITY;
`endif

   state_t             state_q, state_d;
   logic signed [16:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic signed [10:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
   logic               hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               moving_q;

   logic signed [10:0] neg_x_s, neg_y_s, grav_y_s, upd_spd_x_s, upd_spd_y_s;
   logic signed [16:0] sum_x_s, sum_y_s, upd_pos_x_s, upd_pos_y_s;
   logic               edge_x_s, edge_y_s, bounce_s;

   function automatic logic signed [10:0] sat_spd(input logic signed [11:0] v);
      logic signed [11:0] hi;
      logic signed [11:0] lo;
      hi = 12'(MAX_SPEED);
      lo = -hi;
      if (v > hi) begin
         sat_spd = hi[10:0];
      end else if (v < lo) begin
         sat_spd = lo[10:0];
      end else begin
         sat_spd = v[10:0];
      end
   endfunction

   // Clamp one axis to [0, lim] in whole pixels and point the speed back into the screen.
   function automatic void wall(
      input  logic signed [16:0] p,
      input  logic signed [10:0] s,
      input  logic signed [10:0] lim,
      output logic signed [16:0] p_o,
      output logic signed [10:0] s_o,
      output logic               hit_o
   );
      logic signed [10:0] mag;
      mag = s[10] ? -s : s;
      if ($signed(p[16:6]) < 11'sd0) begin
         p_o = 17'sd0;  s_o = mag;  hit_o = 1'b1;
      end else if ($signed(p[16:6]) > lim) begin
         p_o = {lim, 6'd0};  s_o = -mag;  hit_o = 1'b1;
      end else begin
         p_o = p;  s_o = s;  hit_o = 1'b0;
      end
   endfunction

   // Candidate frame update: reflect on latched hits, optional gravity, integrate, border.
   always_comb begin
      neg_x_s  = hit_x_q ? -spd_x_q : spd_x_q;
      neg_y_s  = hit_y_q ? -spd_y_q : spd_y_q;
      grav_y_s = sat_spd({neg_y_s[10], neg_y_s} + 12'(GRAV_STEP));
      sum_x_s  = pos_x_q + {{6{neg_x_s[10]}}, neg_x_s};
      sum_y_s  = pos_y_q + {{6{grav_y_s[10]}}, grav_y_s};
      wall(sum_x_s, neg_x_s, X_LIM, upd_pos_x_s, upd_spd_x_s, edge_x_s);
      wall(sum_y_s, grav_y_s, Y_LIM, upd_pos_y_s, upd_spd_y_s, edge_y_s);
      bounce_s = hit_x_q | hit_y_q | edge_x_s | edge_y_s;
   end

   // Phase sequencing, collision latching and commit of the frame update.
   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      spd_x_d = spd_x_q;
      spd_y_d = spd_y_q;
      hit_x_d = hit_x_q;
      hit_y_d = hit_y_q;
      cnt_d   = cnt_q;
      if (bus.halt) begin
         state_d = IDLE;
         spd_x_d = 11'sd0;
         spd_y_d = 11'sd0;
         hit_x_d = 1'b0;
         hit_y_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.launch) begin
                  state_d = RUN;
                  spd_x_d = sat_spd(12'(INIT_SPEED_X));
                  spd_y_d = sat_spd(12'(INIT_SPEED_Y));
                  hit_x_d = 1'b0;
                  hit_y_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN, COOLDOWN: begin
               if (bus.startOfFrame) begin
                  pos_x_d = upd_pos_x_s;
                  pos_y_d = upd_pos_y_s;
                  spd_x_d = upd_spd_x_s;
                  spd_y_d = upd_spd_y_s;
                  // Pulses coincident with the frame strobe belong to the next frame.
                  hit_x_d = (state_q == RUN) & bus.collisionX;
                  hit_y_d = (state_q == RUN) & bus.collisionY;
                  if (state_q == RUN) begin
                     if (bounce_s) begin
                        state_d = COOLDOWN;
                        cnt_d   = 8'(COOLDOWN_FRAMES);
                     end else begin
                        state_d = RUN;
                     end
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                     if (cnt_q <= 8'd1) begin
                        state_d = RUN;
                     end else begin
                        state_d = COOLDOWN;
                     end
                  end
               end else if (state_q == RUN) begin
                  hit_x_d = hit_x_q | bus.collisionX;
                  hit_y_d = hit_y_q | bus.collisionY;
               end else begin
                  hit_x_d = hit_x_q;
                  hit_y_d = hit_y_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers with asynchronous active-low reset to the idle pose.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= IDLE;
         pos_x_q  <= 17'(INIT_X * 64);
         pos_y_q  <= 17'(INIT_Y * 64);
         spd_x_q  <= 11'sd0;
         spd_y_q  <= 11'sd0;
         hit_x_q  <= 1'b0;
         hit_y_q  <= 1'b0;
         cnt_q    <= 8'd0;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         spd_x_q  <= spd_x_d;
         spd_y_q  <= spd_y_d;
         hit_x_q  <= hit_x_d;
         hit_y_q  <= hit_y_d;
         cnt_q    <= cnt_d;
         moving_q <= (state_d != IDLE);
      end
   end

   assign bus.topLeftX = pos_x_q[16:6];
   assign bus.topLeftY = pos_y_q[16:6];
   assign bus.moving   = moving_q;
endmodule

// File: tb/tb_square_motion_ctrl.sv
// Randomised and directed checks of square_motion_ctrl against a pixel-arithmetic reference model.
module tb_square_motion_ctrl;
   localparam int XL = 608;
   localparam int YL = 448;
   localparam int MAXS = 512;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   square_motion_if bus();

   square_motion_ctrl dut (.clk(clk), .resetN(resetN), .bus(bus));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: position in 1/64 px, phase 0 idle / 1 run / 2 cooldown.
   int m_px, m_py, m_sx, m_sy, m_cd, m_phase;
   bit m_hx, m_hy;

   task automatic model_reset();
      m_px = 280 * 64;  m_py = 185 * 64;
      m_sx = 0;  m_sy = 0;  m_cd = 0;  m_phase = 0;
      m_hx = 1'b0;  m_hy = 1'b0;
   endtask

   task automatic model_frame();
      bit b;
      b = m_hx || m_hy;
      if (m_hx) m_sx = -m_sx;
      if (m_hy) m_sy = -m_sy;
`ifdef SQUARE_MOTION_GRAVITY_EN
      m_sy = (m_sy + 3 > MAXS) ? MAXS : m_sy + 3;
`endif
      m_px = m_px + m_sx;
      m_py = m_py + m_sy;
      if ((m_px >>> 6) < 0) begin
         m_px = 0;  m_sx = (m_sx < 0) ? -m_sx : m_sx;  b = 1'b1;
      end else if ((m_px >>> 6) > XL) begin
         m_px = XL * 64;  m_sx = (m_sx > 0) ? -m_sx : m_sx;  b = 1'b1;
      end
      if ((m_py >>> 6) < 0) begin
         m_py = 0;  m_sy = (m_sy < 0) ? -m_sy : m_sy;  b = 1'b1;
      end else if ((m_py >>> 6) > YL) begin
         m_py = YL * 64;  m_sy = (m_sy > 0) ? -m_sy : m_sy;  b = 1'b1;
      end
      if (m_phase == 1 && b) begin
         m_phase = 2;  m_cd = 4;
      end else if (m_phase == 2) begin
         m_cd = m_cd - 1;
         if (m_cd == 0) m_phase = 1;
      end
   endtask

   task automatic model_apply(input bit sof, input bit la, input bit ha, input bit cx, input bit cy);
      bit was_run;
      if (ha) begin
         m_phase = 0;  m_sx = 0;  m_sy = 0;  m_hx = 1'b0;  m_hy = 1'b0;
      end else if (m_phase == 0) begin
         if (la) begin
            m_phase = 1;  m_sx = 40;  m_sy = -80;  m_hx = 1'b0;  m_hy = 1'b0;
         end
      end else if (sof) begin
         was_run = (m_phase == 1);
         model_frame();
         m_hx = was_run && cx;
         m_hy = was_run && cy;
      end else if (m_phase == 1) begin
         m_hx = m_hx | cx;
         m_hy = m_hy | cy;
      end
   endtask

   function automatic logic [10:0] ex_x();
      return 11'(m_px >>> 6);
   endfunction

   function automatic logic [10:0] ex_y();
      return 11'(m_py >>> 6);
   endfunction

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic tick(input bit sof, input bit la, input bit ha, input bit cx, input bit cy);
      bus.startOfFrame = sof;  bus.launch = la;  bus.halt = ha;
      bus.collisionX = cx;  bus.collisionY = cy;
      model_apply(sof, la, ha, cx, cy);
      @(posedge clk);
      #1;
      bus.startOfFrame = 1'b0;  bus.launch = 1'b0;  bus.halt = 1'b0;
      bus.collisionX = 1'b0;  bus.collisionY = 1'b0;
   endtask

   task automatic frame_with_check(input string tag, input bit cx);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.topLeftX !== ex_x() || bus.topLeftY !== ex_y() || bus.moving !== (m_phase != 0)) begin
         errors++;
         $display("FAIL %s: got x=%0d y=%0d mv=%0b expected x=%0d y=%0d mv=%0b", tag,
                  $signed(bus.topLeftX), $signed(bus.topLeftY), bus.moving,
                  $signed(ex_x()), $signed(ex_y()), (m_phase != 0));
      end
      tick(1'b0, 1'b0, 1'b0, cx, 1'b0);
   endtask

   task automatic test_reset();
      bus.startOfFrame = 1'b0;  bus.launch = 1'b0;  bus.halt = 1'b0;
      bus.collisionX = 1'b0;  bus.collisionY = 1'b0;
      resetN = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 resetN = 1'b1;
      checks++;
      if (bus.topLeftX !== 11'd280 || bus.topLeftY !== 11'd185 || bus.moving !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got x=%0d y=%0d mv=%0b expected 280 185 0",
                  $signed(bus.topLeftX), $signed(bus.topLeftY), bus.moving);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (bus.topLeftX !== 11'd280 || bus.topLeftY !== 11'd185 || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL idle_frames: got x=%0d y=%0d mv=%0b expected 280 185 0",
                     $signed(bus.topLeftX), $signed(bus.topLeftY), bus.moving);
         end
         tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_launch_run();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.moving !== 1'b1 || bus.topLeftX !== 11'd280) begin
         errors++;
         $display("FAIL launch: got mv=%0b x=%0d expected mv=1 x=280", bus.moving, $signed(bus.topLeftX));
      end
      for (int i = 0; i < 64; i++) frame_with_check("run_frame", 1'b0);
`ifndef SQUARE_MOTION_GRAVITY_EN
      checks++;
      if (bus.topLeftX !== 11'd320 || bus.topLeftY !== 11'd105) begin
         errors++;
         $display("FAIL run_64: got x=%0d y=%0d expected 320 105",
                  $signed(bus.topLeftX), $signed(bus.topLeftY));
      end
`endif
   endtask

   task automatic test_collision();
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame_with_check("hit_frame", 1'b0);
      checks++;
      if (bus.topLeftX !== 11'd319) begin
         errors++;
         $display("FAIL collision_neg: got x=%0d expected 319", $signed(bus.topLeftX));
      end
      frame_with_check("cool_frame", 1'b1);
      for (int i = 0; i < 3; i++) frame_with_check("cool_frame", 1'b0);
      checks++;
      if (bus.topLeftX !== 11'd316) begin
         errors++;
         $display("FAIL cooldown_ignore: got x=%0d expected 316", $signed(bus.topLeftX));
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame_with_check("rehit_frame", 1'b0);
      checks++;
      if (bus.topLeftX !== 11'd317) begin
         errors++;
         $display("FAIL collision_renegate: got x=%0d expected 317", $signed(bus.topLeftX));
      end
   endtask

   task automatic test_border();
      bit clamped;
      clamped = 1'b0;
      for (int i = 0; i < 700 && !clamped; i++) begin
         frame_with_check("border_frame", 1'b0);
         clamped = (m_px == XL * 64);
      end
      checks++;
      if (!clamped || bus.topLeftX !== 11'd608) begin
         errors++;
         $display("FAIL border_clamp: got x=%0d reached=%0b expected 608", $signed(bus.topLeftX), clamped);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame_with_check("border_after", 1'b0);
`ifndef SQUARE_MOTION_GRAVITY_EN
      checks++;
      if (bus.topLeftX !== 11'd607) begin
         errors++;
         $display("FAIL border_reverse: got x=%0d expected 607", $signed(bus.topLeftX));
      end
`endif
   endtask

   task automatic test_halt_launch();
      logic [10:0] fx, fy;
      fx = ex_x();
      fy = ex_y();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.moving !== 1'b0 || bus.topLeftX !== fx || bus.topLeftY !== fy) begin
         errors++;
         $display("FAIL halt_priority: got mv=%0b x=%0d y=%0d expected mv=0 x=%0d y=%0d",
                  bus.moving, $signed(bus.topLeftX), $signed(bus.topLeftY), $signed(fx), $signed(fy));
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
         checks++;
         if (bus.topLeftX !== fx || bus.topLeftY !== fy || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL halt_frozen: got x=%0d y=%0d expected %0d %0d",
                     $signed(bus.topLeftX), $signed(bus.topLeftY), $signed(fx), $signed(fy));
         end
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.topLeftX !== fx || bus.topLeftY !== fy || bus.moving !== 1'b1) begin
         errors++;
         $display("FAIL launch_on_sof: got x=%0d y=%0d mv=%0b expected %0d %0d 1",
                  $signed(bus.topLeftX), $signed(bus.topLeftY), bus.moving, $signed(fx), $signed(fy));
      end
      frame_with_check("relaunch_frame", 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 resetN = 1'b0;
      #1;
      model_reset();
      checks++;
      if (bus.topLeftX !== 11'd280 || bus.topLeftY !== 11'd185 || bus.moving !== 1'b0) begin
         errors++;
         $display("FAIL reset_midframe: got x=%0d y=%0d mv=%0b expected 280 185 0",
                  $signed(bus.topLeftX), $signed(bus.topLeftY), bus.moving);
      end
      @(posedge clk);
      #1 resetN = 1'b1;
      frame_with_check("post_reset_frame", 1'b0);
   endtask

   task automatic test_random();
      bit sof, la, ha, cx, cy;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         sof = ($urandom_range(0, 3) == 0);
         la  = ($urandom_range(0, 39) == 0);
         ha  = ($urandom_range(0, 149) == 0);
         cx  = ($urandom_range(0, 7) == 0);
         cy  = ($urandom_range(0, 7) == 0);
         tick(sof, la, ha, cx, cy);
         checks++;
         if (bus.topLeftX !== ex_x() || bus.topLeftY !== ex_y() || bus.moving !== (m_phase != 0)) begin
            errors++;
            $display("FAIL random_cycle%0d: got x=%0d y=%0d mv=%0b expected x=%0d y=%0d mv=%0b", i,
                     $signed(bus.topLeftX), $signed(bus.topLeftY), bus.moving,
                     $signed(ex_x()), $signed(ex_y()), (m_phase != 0));
         end
      end
   endtask

`ifdef SQUARE_MOTION_GRAVITY_EN
   task automatic test_gravity();
      resetN = 1'b0;
      model_reset();
      @(posedge clk);
      #1 resetN = 1'b1;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) frame_with_check("gravity_frame", 1'b0);
      checks++;
      if (bus.topLeftX !== 11'd286 || bus.topLeftY !== 11'd175 || m_sy != -50) begin
         errors++;
         $display("FAIL gravity_10: got x=%0d y=%0d expected 286 175 (model sy=%0d)",
                  $signed(bus.topLeftX), $signed(bus.topLeftY), m_sy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_launch_run();
      test_collision();
      test_border();
      test_halt_launch();
`ifdef SQUARE_MOTION_GRAVITY_EN
      test_gravity();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/square_motion_ctrl.md
# square_motion_ctrl

Per-frame motion controller for one square game object: drives the `topLeftX`/`topLeftY` inputs of a square drawing object. It integrates a fixed-point velocity once per video frame, reflects velocity on collision pulses from the collision detector and on screen-border overshoot, and sequences launch, run and post-bounce cooldown phases. It sits between the VGA frame timing, the collision detector and the object's drawing block.

## Interface
Parameters:
- `OBJECT_WIDTH`, 32: object width in pixels, used for right-border clamping.
- `OBJECT_HEIGHT`, 32: object height in pixels, used for bottom-border clamping.
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `INIT_X`, 280: reset/idle top-left X in pixels.
- `INIT_Y`, 185: reset/idle top-left Y in pixels.
- `INIT_SPEED_X`, 40: launch X speed, in 1/64 px per frame (signed).
- `INIT_SPEED_Y`, -80: launch Y speed, in 1/64 px per frame (signed).
- `MAX_SPEED`, 512: magnitude limit on either speed component, in 1/64 px per frame.
- `COOLDOWN_FRAMES`, 4: frames during which collisions are ignored after a bounce.
- `GRAVITY`, 3: Y acceleration, in 1/64 px per frame² (used only with `SQUARE_MOTION_GRAVITY_EN`).

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: reset; asynchronous, active-low.
- `startOfFrame` in 1: one-cycle pulse, once per frame.
- `launch` in 1: one-cycle request to start motion; honoured only in IDLE.
- `halt` in 1: one-cycle request to stop motion and return to IDLE; position is kept.
- `collisionX` in 1: one-cycle pulse on a vertical-surface hit.
- `collisionY` in 1: one-cycle pulse on a horizontal-surface hit.
- `topLeftX` out 11 signed: integer X position.
- `topLeftY` out 11 signed: integer Y position.
- `moving` out 1: high in RUN or COOLDOWN.

## Operation
- Position is held internally as signed 17-bit values with 6 fractional bits. `topLeftX = posX >>> 6`; `topLeftY` is derived the same way.
- Speeds are held as signed 11-bit values, saturated to ±`MAX_SPEED`.
- State machine:
  - IDLE → RUN on `launch`. Load the speeds with `INIT_SPEED_X`/`INIT_SPEED_Y` and clear the collision latches.
  - RUN → COOLDOWN on any frame update that performs a bounce. Load the frame counter with `COOLDOWN_FRAMES`.
  - COOLDOWN: decrement the counter on each `startOfFrame`. Go to RUN when the counter reaches 0. Motion and border handling continue during COOLDOWN.
  - Any state → IDLE on `halt`. Speeds are zeroed and position is unchanged. `halt` takes priority over `launch`.
- Collision latches:
  - In RUN, `collisionX` sets `hitX` and `collisionY` sets `hitY`.
  - In IDLE and COOLDOWN, collision pulses are dropped.
  - Pulses arriving in the same cycle as `startOfFrame` are latched for the next frame.
- Frame update, on `startOfFrame` in RUN or COOLDOWN:
  1. If `hitX`, negate `speedX`. If `hitY`, negate `speedY`. Clear both latches.
  2. Add the speeds to the positions.
  3. Border handling:
     - If integer X < 0, clamp X to 0 and force `speedX` positive.
     - If integer X > `SCREEN_W - OBJECT_WIDTH`, clamp X to that value and force `speedX` negative.
     - Y is handled the same way against 0 and `SCREEN_H - OBJECT_HEIGHT`.
  4. If any negation or border force occurred, it counts as a bounce.
- Negation of −`MAX_SPEED` yields +`MAX_SPEED`; no overflow is allowed.

## Timing
- Reset values:
  - `topLeftX` = `INIT_X`, `topLeftY` = `INIT_Y`.
  - `moving` = 0, state IDLE.
  - Speeds 0, latches 0, counter 0.
- `launch`/`halt` take effect on the next clock edge; `moving` rises or falls one cycle after the request.
- Frame update latency: `topLeftX`/`topLeftY` change exactly one cycle after the edge sampling `startOfFrame`. They are stable for the rest of the frame.
- `launch` coincident with `startOfFrame` in IDLE: RUN is entered with no position change; first movement occurs on the next frame.
- `resetN` asserted mid-frame immediately restores all reset values.

## Configuration
- `SQUARE_MOTION_GRAVITY_EN`
  - Defined: after step 1 of the frame update, `speedY += GRAVITY`, saturated at +`MAX_SPEED`. Gravity applies in RUN and COOLDOWN only.
  - Undefined: `speedY` changes only through bounces; the `GRAVITY` parameter is unused.

## Test plan
- Reset, then 3 `startOfFrame` pulses with no `launch` → `topLeftX`/`topLeftY` remain 280/185 and `moving` = 0.
- `launch`, then 64 frames (gravity off) → `topLeftX` = 280+40 = 320, `topLeftY` = 185−80 = 105.
- In RUN, pulse `collisionX` mid-frame → on the next frame X decreases by 40/64 px per frame. A second `collisionX` within 4 frames is ignored, and one after 4 frames re-negates the X speed.
- Start at X ≈ 607 moving right → X clamps to 608, `speedX` becomes negative and the state enters COOLDOWN.
- `halt` and `launch` in the same cycle while in RUN → IDLE, `moving` = 0 and position frozen. Asserting `resetN` low mid-frame restores 280/185.
- With `SQUARE_MOTION_GRAVITY_EN` defined, `launch` then 10 frames → `speedY` = −80+30 = −50 and `topLeftY` follows the cumulative sum.
